// File: rtl/uc_seq_if.sv
// Control bus between the sequencer (uc_seq) and the single-cycle datapath.
// master: the sequencer side (decodes, drives strobes); slave: the datapath side.
interface uc_seq_if;
    logic        run;
    logic [15:0] opcode;
    logic        z;
    logic [3:0]  in_valid;
    logic [3:0]  in_ack;
    logic        pc_en;
    logic        s_inc;
    logic        s_pila;
    logic        push;
    logic        pop;
    logic        we3;
    logic        wez;
    logic        we4;
    logic        we5;
    logic        s_out;
    logic [1:0]  s_inm;
    logic [1:0]  s_port;
    logic [2:0]  op_alu;
    logic        halted;
    logic        fault;

    modport master (
        input  run, opcode, z, in_valid,
        output in_ack, pc_en, s_inc, s_pila, push, pop, we3, wez, we4, we5, s_out,
        output s_inm, s_port, op_alu, halted, fault
    );

    modport slave (
        output run, opcode, z, in_valid,
        input  in_ack, pc_en, s_inc, s_pila, push, pop, we3, wez, we4, we5, s_out,
        input  s_inm, s_port, op_alu, halted, fault
    );
endinterface

// File: rtl/uc_seq.sv
// Sequencing control unit for the single-cycle CPU datapath.
// Decodes opcode[15:12] into datapath strobes, owns run/stall/halt/fault state and
// tracks return-stack depth so CALL overflow / RET underflow trap to FAULT.
// Optional feature macro: UC_IN_HANDSHAKE_EN (IN waits on in_valid, in_ack driven).
module uc_seq #(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    uc_seq_if.master bus
);
    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

`ifdef UC_IN_HANDSHAKE_EN
    typedef enum logic [2:0] {StIdle, StRun, StWaitIn, StHalt, StFault} state_e;
`else
    typedef enum logic [2:0] {StIdle, StRun, StHalt, StFault} state_e;
`endif

    state_e              state_q, state_d;
    logic [DepthW-1:0]   depth_q, depth_d;

    logic [3:0] opc;
    logic [1:0] sel;
    logic [1:0] port;
    logic       port_rdy;
    logic       is_in, is_call, is_ret, is_halt;
    logic       stack_full, stack_empty;
    logic       taken;

    assign opc     = bus.opcode[15:12];
    assign sel     = bus.opcode[11:10];
    assign port    = bus.opcode[5:4];
    assign is_in   = (opc == 4'hB);
    assign is_call = (opc == 4'hE) && (sel == 2'b11);
    assign is_ret  = (opc == 4'hF) && (sel == 2'b00);
    assign is_halt = (opc == 4'hF) && (sel == 2'b11);

    assign stack_full  = (depth_q == DepthW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);

`ifdef UC_IN_HANDSHAKE_EN
    assign port_rdy = bus.in_valid[port];
    logic unused_bits;
    assign unused_bits = ^{bus.opcode[9:6], bus.opcode[3:0]};
`else
    // Without the handshake every IN completes in its own cycle.
    assign port_rdy = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{bus.opcode[9:6], bus.opcode[3:0], bus.in_valid};
`endif

    // Branch condition: J and CALL always taken, JZ on z=1, JNZ on z=0.
    always_comb begin
        taken = 1'b1;
        unique case (sel)
            2'b01:   taken = bus.z;
            2'b10:   taken = ~bus.z;
            default: taken = 1'b1;
        endcase
    end

    // State and stack-depth registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

    // Next state and depth; depth never wraps because overflow/underflow trap instead.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        unique case (state_q)
            StIdle: if (bus.run) state_d = StRun;
            StRun: begin
                if (!bus.run) begin
                    state_d = StIdle;
`ifdef UC_IN_HANDSHAKE_EN
                end else if (is_in && !port_rdy) begin
                    state_d = StWaitIn;
`endif
                end else if (is_halt) begin
                    state_d = StHalt;
                end else if (is_call) begin
                    if (stack_full) state_d = StFault;
                    else            depth_d = depth_q + DepthW'(1);
                end else if (is_ret) begin
                    if (stack_empty) state_d = StFault;
                    else             depth_d = depth_q - DepthW'(1);
                end
            end
`ifdef UC_IN_HANDSHAKE_EN
            StWaitIn: begin
                if (!bus.run)     state_d = StIdle;
                else if (port_rdy) state_d = StRun;
            end
`endif
            default: ;
        endcase
    end

    // Strobe decode from state, opcode, z and in_valid.
    always_comb begin
        bus.pc_en  = 1'b0;
        bus.s_inc  = 1'b0;
        bus.s_pila = 1'b0;
        bus.push   = 1'b0;
        bus.pop    = 1'b0;
        bus.we3    = 1'b0;
        bus.wez    = 1'b0;
        bus.we4    = 1'b0;
        bus.we5    = 1'b0;
        bus.s_out  = 1'b0;
        bus.s_inm  = 2'b00;
        bus.s_port = 2'b00;
        bus.op_alu = 3'b000;
        bus.in_ack = 4'b0000;
        bus.halted = 1'b0;
        bus.fault  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.run) begin
                    bus.pc_en = 1'b1;
                    bus.s_inc = 1'b1;
                    if (!opc[3]) begin
                        bus.op_alu = opc[2:0];
                        bus.we3    = 1'b1;
                        bus.wez    = 1'b1;
                    end else begin
                        unique case (opc[2:0])
                            3'b000: begin bus.we3 = 1'b1; bus.s_inm = 2'b01; end
                            3'b001: begin bus.we3 = 1'b1; bus.s_inm = 2'b10; end
                            3'b010: bus.we4 = 1'b1;
                            3'b011: begin
                                bus.s_inm  = 2'b11;
                                bus.s_port = port;
                                if (port_rdy) begin
                                    bus.we3 = 1'b1;
`ifdef UC_IN_HANDSHAKE_EN
                                    bus.in_ack[port] = 1'b1;
`endif
                                end else begin
                                    bus.pc_en = 1'b0;
                                end
                            end
                            3'b100: bus.we5 = 1'b1;
                            3'b101: begin bus.we5 = 1'b1; bus.s_out = 1'b1; end
                            3'b110: begin
                                bus.s_inc = ~taken;
                                if (sel == 2'b11) begin
                                    // Overflowing CALL: no push, PC frozen.
                                    bus.push  = ~stack_full;
                                    bus.pc_en = ~stack_full;
                                end
                            end
                            default: begin
                                if (sel == 2'b00) begin
                                    bus.s_pila = 1'b1;
                                    bus.pop    = ~stack_empty;
                                    bus.pc_en  = ~stack_empty;
                                end else if (sel == 2'b11) begin
                                    bus.pc_en = 1'b0;
                                end
                            end
                        endcase
                    end
                end
            end
`ifdef UC_IN_HANDSHAKE_EN
            StWaitIn: begin
                if (bus.run && port_rdy) begin
                    bus.pc_en        = 1'b1;
                    bus.s_inc        = 1'b1;
                    bus.s_inm        = 2'b11;
                    bus.s_port       = port;
                    bus.we3          = 1'b1;
                    bus.in_ack[port] = 1'b1;
                end
            end
`endif
            StHalt:  bus.halted = 1'b1;
            StFault: bus.fault  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq: stimulus pushes the expected output vector computed by a
// behavioural model; a negedge monitor pops and compares against the DUT.
module tb_uc_seq;
    localparam int SD = 8;
`ifdef UC_IN_HANDSHAKE_EN
    localparam bit Hs = 1'b1;
`else
    localparam bit Hs = 1'b0;
`endif
    localparam int MIdle = 0, MRun = 1, MWait = 2, MHalt = 3, MFault = 4;

    typedef struct {
        logic [22:0] v;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    uc_seq_if bus ();

    uc_seq #(.STACK_DEPTH(SD)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   m_mode  = MIdle;
    int   m_depth = 0;

    function automatic logic [22:0] actual();
        return {bus.pc_en, bus.s_inc, bus.s_pila, bus.push, bus.pop, bus.we3, bus.wez,
                bus.we4, bus.we5, bus.s_out, bus.s_inm, bus.s_port, bus.op_alu,
                bus.in_ack, bus.halted, bus.fault};
    endfunction

    // Reference model: expected outputs for this cycle and the mode for the next one.
    task automatic model(input logic rst_l, input logic run, input logic [15:0] op,
                         input logic z, input logic [3:0] iv, output logic [22:0] e);
        logic pc = 0, inc = 0, pila = 0, psh = 0, pp = 0, w3 = 0, wz = 0, w4 = 0, w5 = 0;
        logic so = 0, hl = 0, ft = 0;
        logic [1:0] inm = 0, sp = 0;
        logic [2:0] alu = 0;
        logic [3:0] ack = 0;
        int nxt = m_mode;
        int p = int'(op[5:4]);
        int cls = int'(op[15:12]);
        int sub = int'(op[11:10]);
        bit rdy = !Hs || iv[p];
        if (!rst_l) begin
            nxt = MIdle;
            m_depth = 0;
        end else if (m_mode == MIdle) begin
            if (run) nxt = MRun;
        end else if (m_mode == MHalt) begin
            hl = 1;
        end else if (m_mode == MFault) begin
            ft = 1;
        end else if (!run) begin
            nxt = MIdle;
        end else if (m_mode == MWait) begin
            if (rdy) begin
                pc = 1; inc = 1; inm = 3; sp = op[5:4]; w3 = 1; ack = 4'(1 << p);
                nxt = MRun;
            end
        end else begin
            pc = 1; inc = 1;
            if (cls < 8) begin
                alu = op[14:12]; w3 = 1; wz = 1;
            end else if (cls == 8) begin
                w3 = 1; inm = 1;
            end else if (cls == 9) begin
                w3 = 1; inm = 2;
            end else if (cls == 10) begin
                w4 = 1;
            end else if (cls == 11) begin
                inm = 3; sp = op[5:4];
                if (rdy) begin
                    w3 = 1; ack = Hs ? 4'(1 << p) : 4'b0;
                end else begin
                    pc = 0; nxt = MWait;
                end
            end else if (cls == 12) begin
                w5 = 1;
            end else if (cls == 13) begin
                w5 = 1; so = 1;
            end else if (cls == 14) begin
                inc = !(sub == 0 || sub == 3 || (sub == 1 && z) || (sub == 2 && !z));
                if (sub == 3) begin
                    if (m_depth == SD) begin pc = 0; nxt = MFault; end
                    else begin psh = 1; m_depth++; end
                end
            end else begin
                if (sub == 0) begin
                    pila = 1;
                    if (m_depth == 0) begin pc = 0; nxt = MFault; end
                    else begin pp = 1; m_depth--; end
                end else if (sub == 3) begin
                    pc = 0; nxt = MHalt;
                end
            end
        end
        m_mode = nxt;
        e = {pc, inc, pila, psh, pp, w3, wz, w4, w5, so, inm, sp, alu, ack, hl, ft};
    endtask

    task automatic step(input logic rst_l, input logic run, input logic [15:0] op,
                        input logic z, input logic [3:0] iv, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst_l;
        bus.run = run;
        bus.opcode = op;
        bus.z = z;
        bus.in_valid = iv;
        model(rst_l, run, op, z, iv, x.v);
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [22:0] a;
            x = exp_q.pop_front();
            a = actual();
            n_total++;
            if (a !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %06h want %06h (t=%0t)", x.tag, a, x.v, $time);
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.run = 1'b1;
        bus.opcode = 16'hF400;
        bus.z = 1'b0;
        bus.in_valid = 4'b0;

        repeat (3) step(1'b0, 1'b1, 16'h2123, 1'b0, 4'hF, "reset_hold");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "release_idle");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "first_run");
        step(1'b1, 1'b1, 16'h2123, 1'b0, 4'h0, "alu_op2");
        step(1'b1, 1'b1, 16'hE40A, 1'b0, 4'h0, "jz_not_taken");
        step(1'b1, 1'b1, 16'hE40A, 1'b1, 4'h0, "jz_taken");
        step(1'b1, 1'b1, 16'hE80A, 1'b0, 4'h0, "jnz_taken");
        step(1'b1, 1'b1, 16'hE80A, 1'b1, 4'h0, "jnz_not_taken");
        step(1'b1, 1'b1, 16'h8005, 1'b0, 4'h0, "li");
        step(1'b1, 1'b1, 16'hD005, 1'b0, 4'h0, "out_imm");
        repeat (3) step(1'b1, 1'b1, 16'hB020, 1'b0, 4'b1011, "in_wait");
        step(1'b1, 1'b1, 16'hB020, 1'b0, 4'b0100, "in_done");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'b0100, "after_in");
        step(1'b1, 1'b1, 16'hB010, 1'b0, 4'b0010, "in_ready_now");
        step(1'b1, 1'b0, 16'hF400, 1'b0, 4'h0, "run_low");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "idle_again");

        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 16'hEC00, 1'b0, 4'h0, "call_chain");
        repeat (2) step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "fault_sticky");
        step(1'b0, 1'b1, 16'hF400, 1'b0, 4'h0, "reset_fault");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "idle3");
        step(1'b1, 1'b1, 16'hF000, 1'b0, 4'h0, "ret_underflow");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "fault_after_ret");
        step(1'b0, 1'b1, 16'hF400, 1'b0, 4'h0, "reset_fault2");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "idle4");
        step(1'b1, 1'b1, 16'hFC00, 1'b0, 4'h0, "halt");
        repeat (3) step(1'b1, 1'b1, 16'h2123, 1'b0, 4'h0, "halted_hold");
        step(1'b0, 1'b1, 16'hF400, 1'b0, 4'h0, "reset_halt");
        step(1'b1, 1'b1, 16'hF400, 1'b0, 4'h0, "idle5");
        step(1'b1, 1'b1, 16'hB030, 1'b0, 4'h0, "in_wait2");
        step(1'b1, 1'b1, 16'hB030, 1'b0, 4'h0, "in_wait3");
        step(1'b0, 1'b1, 16'hB030, 1'b0, 4'hF, "reset_mid_wait");
        step(1'b1, 1'b1, 16'hB030, 1'b0, 4'hF, "idle_after_wait");

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] op;
            op = 16'($urandom);
            if ($urandom_range(0, 3) == 0) op[15:12] = 4'hB;
            if (op[15:10] == 6'b111111 && $urandom_range(0, 3) != 0) op[11:10] = 2'b01;
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 15) != 0), op,
                 1'($urandom), 4'($urandom), "random");
        end

        @(posedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
